vx_dram_responder: RTL
======================

// Module: vx_dram_responder
// PURPOSE
//  DRAM-side responder for a cache DRAM port: accepts dram_req_* (valid/ready), services it from an on-chip line store, and returns dram_rsp_* for reads.
//  Used as the DRAM endpoint for a dcache/icache in simulation and FPGA bring-up, with no external memory controller.
//  Writes are posted (no response). Reads return in order after a fixed latency, through a credit-limited response queue.
// PARAMETERS
//  LINE_WIDTH      128  bits per DRAM line (req/rsp data width)
//  ADDR_WIDTH      28   line address width
//  TAG_WIDTH       28   request/response tag width
//  MEM_DEPTH_LOG2  10   log2 of lines in store; index = addr[MEM_DEPTH_LOG2-1:0]
//  LATENCY         4    read accept -> rsp_valid, in cycles; legal range >= 2
//  RSPQ_SIZE       4    max outstanding reads (pipeline + queue); power of 2, >= 2
// PORTS
//  clk             in   1             clock
//  reset           in   1             one clock; reset is asynchronous and active-low
//  dram_req_valid  in   1             request valid
//  dram_req_rw     in   1             1 = write, 0 = read
//  dram_req_byteen in   LINE_WIDTH/8  write byte enables
//  dram_req_addr   in   ADDR_WIDTH    line address
//  dram_req_data   in   LINE_WIDTH    write data
//  dram_req_tag    in   TAG_WIDTH     request tag
//  dram_req_ready  out  1             request accepted when valid & ready
//  dram_rsp_valid  out  1             read response valid
//  dram_rsp_data   out  LINE_WIDTH    read data
//  dram_rsp_tag    out  TAG_WIDTH     tag of the originating read
//  dram_rsp_ready  in   1             response consumed when valid & ready
// BEHAVIOUR
//  - Reset (reset=0, async): credits=0; pipeline valids=0; queue empty; dram_rsp_valid=0; dram_req_ready=0.
//    Line store is not reset. A reset mid-operation drops all in-flight reads; no response is produced for them.
//  - credits: reads accepted but not yet popped. +1 on read accept, -1 on response pop, unchanged when both occur in the same cycle.
//  - dram_req_ready = (credits < RSPQ_SIZE); asserted from the first cycle after reset release. Reads and writes are gated alike.
//  - Write accept: store[idx] bytes with byteen=1 take the new data; other bytes are unchanged. Effective at the following edge.
//  - Read accept at edge t: data from store[idx] plus tag enter the delay pipeline. The entry reaches the queue so that
//    dram_rsp_valid is high from edge t+LATENCY when the queue is empty.
//  - Read-after-write to the same idx in consecutive cycles returns the written data. No same-cycle conflict is possible (one request per cycle).
//  - The pipeline never stalls. Credits guarantee the queue cannot overflow, so queue full with a pipeline push is illegal and is flagged by an assertion.
//  - Response queue: FIFO of RSPQ_SIZE entries. dram_rsp_* show the head; pop on valid & ready.
//    Data/tag hold stable while valid & !ready. Push and pop in the same cycle are legal at any occupancy, including full.
//  - Responses are strictly in request order; tag is returned unmodified.
//  - Address bits above MEM_DEPTH_LOG2 are ignored (aliasing).
// CONFIGURATION
//  DRAM_RESPONDER_PERF_EN defined: adds outputs perf_reads[31:0], perf_writes[31:0], perf_stalls[31:0].
//    perf_reads / perf_writes count accepted reads / writes. perf_stalls counts cycles with valid & !ready.
//    All three reset to 0 and wrap modulo 2^32.
//  DRAM_RESPONDER_PERF_EN undefined: these ports and their counters are absent; all other behaviour is identical.
// TESTING
//  1. Write addr 0x5, data 0xA..A, byteen all 1; next cycle read addr 0x5, tag 0x12
//     -> rsp_valid at accept+LATENCY, data 0xA..A, tag 0x12.
//  2. Write 0x11..11 to addr 3; then write 0xFF..FF with byteen 0x0001; read addr 3
//     -> data 0x11..11FF (only byte 0 changed).
//  3. rsp_ready=0; issue reads until req_ready falls
//     -> exactly RSPQ_SIZE accepts; raise rsp_ready -> tags return in issue order and req_ready rises the cycle after the first pop.
//  4. Queue full, rsp_ready=1, read presented each cycle
//     -> one accept and one pop per cycle sustained; credits stay at RSPQ_SIZE-1..RSPQ_SIZE, never exceed.
//  5. Assert reset with 3 reads in flight
//     -> rsp_valid and req_ready drop immediately; after release, no stale responses and credits=0.
//  6. PERF_EN build: 7 reads, 2 writes, 5 stall cycles
//     -> perf_reads=7, perf_writes=2, perf_stalls=5.

Source files
------------

// File: rtl/vx_dram_responder.sv
// vx_dram_responder: DRAM-side endpoint backed by an on-chip line store.
// Writes are posted with byte enables. Reads return in order after LATENCY
// cycles through a credit-limited response queue.
// Optional feature macro: DRAM_RESPONDER_PERF_EN adds perf_reads, perf_writes
// and perf_stalls counters.
module vx_dram_responder #(
  parameter int LINE_WIDTH     = 128,
  parameter int ADDR_WIDTH     = 28,
  parameter int TAG_WIDTH      = 28,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int LATENCY        = 4,
  parameter int RSPQ_SIZE      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dram_req_valid,
  input  logic                    dram_req_rw,
  input  logic [LINE_WIDTH/8-1:0] dram_req_byteen,
  input  logic [ADDR_WIDTH-1:0]   dram_req_addr,
  input  logic [LINE_WIDTH-1:0]   dram_req_data,
  input  logic [TAG_WIDTH-1:0]    dram_req_tag,
  output logic                    dram_req_ready,
  output logic                    dram_rsp_valid,
  output logic [LINE_WIDTH-1:0]   dram_rsp_data,
  output logic [TAG_WIDTH-1:0]    dram_rsp_tag,
  input  logic                    dram_rsp_ready
`ifdef DRAM_RESPONDER_PERF_EN
  ,
  output logic [31:0]             perf_reads,
  output logic [31:0]             perf_writes,
  output logic [31:0]             perf_stalls
`endif
);

  localparam int BYTES = LINE_WIDTH / 8;
  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam int PTR_W = $clog2(RSPQ_SIZE);
  localparam int CNT_W = PTR_W + 1;

  logic                      alive;
  logic [CNT_W-1:0]          credits;
  logic                      req_fire;
  logic                      wr_fire;
  logic                      rd_fire;
  logic                      pop;
  logic                      push;
  logic [MEM_DEPTH_LOG2-1:0] idx;

  logic [LINE_WIDTH-1:0]     store [DEPTH];

  logic [LATENCY-1:0]        vld_p;
  logic [LINE_WIDTH-1:0]     data_p [LATENCY];
  logic [TAG_WIDTH-1:0]      tag_p  [LATENCY];

  logic [LINE_WIDTH-1:0]     q_data [RSPQ_SIZE];
  logic [TAG_WIDTH-1:0]      q_tag  [RSPQ_SIZE];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [CNT_W-1:0]          q_cnt;
  logic                      q_full;

  assign idx      = dram_req_addr[MEM_DEPTH_LOG2-1:0];
  assign req_fire = dram_req_valid && dram_req_ready;
  assign wr_fire  = req_fire && dram_req_rw;
  assign rd_fire  = req_fire && !dram_req_rw;
  assign pop      = dram_rsp_valid && dram_rsp_ready;
  assign push     = vld_p[LATENCY-1];
  assign q_full   = (q_cnt == CNT_W'(RSPQ_SIZE));

  // Upper address bits alias onto the same line and are intentionally dropped.
  generate
    if (ADDR_WIDTH > MEM_DEPTH_LOG2) begin : g_alias
      logic unused_addr_hi;
      assign unused_addr_hi = ^dram_req_addr[ADDR_WIDTH-1:MEM_DEPTH_LOG2];
    end
  endgenerate

  // Ready is held low until the first clock after reset release.
  assign dram_req_ready = alive && (credits < CNT_W'(RSPQ_SIZE));

  // Marks the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) alive <= 1'b0;
    else        alive <= 1'b1;
  end

  // Credits track reads accepted but not yet popped from the response queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credits <= '0;
    end else begin
      case ({rd_fire, pop})
        2'b10:   credits <= credits + CNT_W'(1);
        2'b01:   credits <= credits - CNT_W'(1);
        default: credits <= credits;
      endcase
    end
  end

  // Line store write with per-byte enables; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < BYTES; b++) begin
        if (dram_req_byteen[b]) store[idx][b*8 +: 8] <= dram_req_data[b*8 +: 8];
      end
    end
  end

  // Stage p0 captures the read; later stages delay it to reach LATENCY.
  always_ff @(posedge clk) begin
    data_p[0] <= store[idx];
    tag_p[0]  <= dram_req_tag;
    for (int k = 1; k < LATENCY; k++) begin
      data_p[k] <= data_p[k-1];
      tag_p[k]  <= tag_p[k-1];
    end
  end

  // Pipeline valids: never stall, cleared on reset to drop in-flight reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_p <= '0;
    else        vld_p <= {vld_p[LATENCY-2:0], rd_fire};
  end

  // Response queue storage; a full-queue push only coincides with a pop.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= data_p[LATENCY-1];
      q_tag[wr_ptr]  <= tag_p[LATENCY-1];
    end
  end

  // Response queue pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   q_cnt <= q_cnt + CNT_W'(1);
        2'b01:   q_cnt <= q_cnt - CNT_W'(1);
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  assign dram_rsp_valid = (q_cnt != '0);
  assign dram_rsp_data  = q_data[rd_ptr];
  assign dram_rsp_tag   = q_tag[rd_ptr];

  // Credits make overflow unreachable; flag it if it ever happens.
  assert property (@(posedge clk) disable iff (!reset) !(q_full && push && !pop));

`ifdef DRAM_RESPONDER_PERF_EN
  // Accepted-request and back-pressure counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_reads  <= '0;
      perf_writes <= '0;
      perf_stalls <= '0;
    end else begin
      if (rd_fire) perf_reads  <= perf_reads + 32'd1;
      if (wr_fire) perf_writes <= perf_writes + 32'd1;
      if (dram_req_valid && !dram_req_ready) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule
